// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: job control, product input and psum output handshakes of the psum stage
interface psum_accumulator_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [3:0]        cfg_len;
    logic [3:0]        cfg_pass;
    logic              busy;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              done;
    logic              sat_flag;

    modport master (
        output start, cfg_len, cfg_pass, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, done, sat_flag
    );

    modport slave (
        input  start, cfg_len, cfg_pass, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, done, sat_flag
    );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator: saturating multi-pass psum scratchpad that drains its entries in order after the last pass
module psum_accumulator #(
    parameter int DATA_W     = 16,
    parameter int PSUM_DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    psum_accumulator_if.slave bus_if
);
    localparam int IW = PSUM_DEPTH > 1 ? $clog2(PSUM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        len_q, len_d, pass_q, pass_d, pcnt_q, pcnt_d;
    logic              sat_q, sat_d, done_q, done_d;
    logic [DATA_W-1:0] spad_q [PSUM_DEPTH];
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        len_c;
    logic              ovf, in_fire, out_fire, last_idx, last_pass;

    assign in_fire   = state_q == ACCUM && bus_if.in_valid;
    assign out_fire  = state_q == DRAIN && bus_if.out_ready;
    assign last_idx  = {{(4-IW){1'b0}}, idx_q} == len_q - 4'd1;
    assign last_pass = pcnt_q == pass_q - 4'd1;
    assign len_c     = bus_if.cfg_len == 4'd0 ? 4'd1 :
                       bus_if.cfg_len > 4'(PSUM_DEPTH) ? 4'(PSUM_DEPTH) : bus_if.cfg_len;

    // Sign-extended add: overflow shows up as disagreement of the top two bits
    assign sum   = {spad_q[idx_q][DATA_W-1], spad_q[idx_q]} + {bus_if.in_data[DATA_W-1], bus_if.in_data};
    assign ovf   = sum[DATA_W] != sum[DATA_W-1];
    assign wdata = pcnt_q == 4'd0 ? bus_if.in_data :
                   !ovf ? sum[DATA_W-1:0] :
                   sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

    assign bus_if.busy      = state_q != IDLE;
    assign bus_if.in_ready  = state_q == ACCUM;
    assign bus_if.out_valid = state_q == DRAIN;
    assign bus_if.out_data  = state_q == DRAIN ? spad_q[idx_q] : '0;
    assign bus_if.done      = done_q;
    assign bus_if.sat_flag  = sat_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pass_d  = pass_q;
        pcnt_d  = pcnt_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        if (state_q == IDLE && bus_if.start) begin
            state_d = ACCUM;
            idx_d   = '0;
            pcnt_d  = '0;
            sat_d   = 1'b0;
            len_d   = len_c;
            pass_d  = bus_if.cfg_pass == 4'd0 ? 4'd1 : bus_if.cfg_pass;
        end else if (in_fire) begin
            idx_d   = last_idx ? '0 : idx_q + 1'b1;
            pcnt_d  = last_idx ? pcnt_q + 4'd1 : pcnt_q;
            sat_d   = sat_q | (pcnt_q != 4'd0 && ovf);
            state_d = last_idx && last_pass ? DRAIN : ACCUM;
        end else if (out_fire) begin
            idx_d   = last_idx ? '0 : idx_q + 1'b1;
            state_d = last_idx ? IDLE : DRAIN;
            done_d  = last_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= 4'd1;
            pass_q  <= 4'd1;
            pcnt_q  <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            pcnt_q  <= pcnt_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    // Scratchpad is never reset: pass 0 overwrites every used entry
    always_ff @(posedge clk) begin
        if (in_fire) spad_q[idx_q] <= wdata;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Downstream partial-sum stage of the PE, consuming the 16-bit dot-product result (RES) of vector_mult one product per handshake. Keeps a small psum scratchpad of PSUM_DEPTH entries and accumulates cfg_pass successive products into each entry with saturating two's-complement addition. When the last pass completes, it drains the entries in order over a valid/ready output to the next psum consumer (neighbouring PE or global buffer).

Parameters:
DATA_W, 16, width of products and psums; 16-bit two's complement.
PSUM_DEPTH, 8, number of scratchpad entries; power of two, at most 8.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; begins a job; sampled only in IDLE.
cfg_len  in  4  number of entries used; sampled with start.
cfg_pass  in  4  number of products accumulated per entry; sampled with start.
busy  out  1  high in ACCUM and DRAIN.
in_valid  in  1  product valid (from vector_mult side).
in_data  in  DATA_W  product value (vector_mult RES).
in_ready  out  1  high only in ACCUM.
out_valid  out  1  psum valid.
out_data  out  DATA_W  psum value.
out_ready  in  1  consumer ready.
done  out  1  one-cycle pulse after the last psum is drained.
sat_flag  out  1  sticky; set when any add saturated during the current job.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, entry index=0, pass counter=0, busy=0, in_ready=0, out_valid=0, out_data=0, done=0, sat_flag=0. Scratchpad contents are not reset; pass 0 overwrites them.
- States: IDLE, ACCUM, DRAIN.
- IDLE: when start=1, latch len=max(cfg_len,1) clamped to PSUM_DEPTH and pass=max(cfg_pass,1). Clear sat_flag and both counters, then go to ACCUM next cycle. When start=0, stay. Any start seen outside IDLE is ignored.
- ACCUM: in_ready=1. Fire = in_valid && in_ready.
  - On fire at pass 0: spad[idx] <= in_data.
  - On fire at a later pass: spad[idx] <= sat(spad[idx] + in_data).
  - idx increments each fire. When idx reaches len-1 it wraps to 0 and the pass counter increments.
  - The fire with idx=len-1 and pass counter=pass-1 moves the state to DRAIN on the next cycle.
- Saturation: sum is formed at DATA_W+1 bits. If it is above 0x7FFF, write 0x7FFF; if below 0x8000 (signed), write 0x8000. Either case sets sat_flag. Products are never truncated silently.
- DRAIN:
  - in_ready=0, out_valid=1, out_data=spad[drain_idx] (drain_idx starts at 0).
  - On out_valid && out_ready, drain_idx increments. out_data and out_valid hold stable while out_ready=0.
  - The fire with drain_idx=len-1 moves the state to IDLE and pulses done=1 for exactly one cycle. On that done cycle busy=0 and out_valid=0.
- Latency:
  - start at cycle t gives in_ready=1 at t+1.
  - Last product accepted at cycle k gives out_valid=1 with entry 0 at k+1. This also holds for len=1: the scratchpad write at edge k is visible at k+1.
  - Minimum job length: 1 + len·pass + len cycles, plus 1 for done.
- Reset mid-operation: abort immediately to the reset values. No done pulse. A new start is required.
- sat_flag stays valid until the next accepted start.

Test Plan:
1. len=1, pass=3, products 0x0090, 0xFF70, 0xFF70 → one output, out_data=0xFF70; done 1 cycle after that output fires; sat_flag=0.
2. len=2, pass=2, products 0x0100, 0x0200, 0x0010, 0xFFF0 → outputs 0x0110 then 0x01F0 in order; out_valid first high the cycle after the 4th accept.
3. Saturation: len=1, pass=2. Products 0x7000, 0x7000 → out_data=0x7FFF, sat_flag=1. Next job with products 0x9000, 0x9000 → start clears sat_flag, then out_data=0x8000 with sat_flag=1.
4. Backpressure: hold in_valid low randomly during ACCUM, and hold out_ready low for 5 cycles during DRAIN → out_data/out_valid stable while stalled, no entry skipped or duplicated, sums unchanged.
5. Illegal config and start while busy: start with cfg_len=0, cfg_pass=0 → behaves as len=1, pass=1 (output equals the single product). A second start pulse mid-job → ignored, outputs unchanged.
6. Reset mid-job: drop rst_n during ACCUM after 3 accepts → busy=0, in_ready=0, out_valid=0, no done. A fresh job afterwards gives correct sums with no stale scratchpad contribution.
